// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and state type for the TDM demux; frame length depends on TDM_DEMUX_PARITY_EN
package tdm_pkg;

    localparam int SLOTS = 16;

`ifdef TDM_DEMUX_PARITY_EN
    // Sixteen data slots followed by one even-parity slot
    localparam int FRAME_LEN = SLOTS + 1;
`else
    localparam int FRAME_LEN = SLOTS;
`endif

    // Wide enough to index slot 16 when the parity slot is present
    localparam int SLOT_W = 5;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - wrapping frame slot counter with load-to-1 and clear
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load1,
    input  logic              clr,
    output logic [SLOT_W-1:0] cnt
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;

    // Clear beats load, load beats increment; increment wraps after the last slot
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = SLOT_W'(1);
        end else if (inc) begin
            cnt_d = (cnt_q == LAST_SLOT) ? '0 : cnt_q + SLOT_W'(1);
        end
    end

    // Slot register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tdm_demux16.sv
// rtl/tdm_demux16.sv - 16-slot serial TDM demultiplexer with frame-sync tracking; TDM_DEMUX_PARITY_EN adds a parity slot
module tdm_demux16
    import tdm_pkg::*;
#(
    parameter int MISS_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_en,
    input  logic        fsync,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic [3:0]  slot,
    output logic        locked,
    output logic        sync_err,
    output logic        parity_err
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);
    localparam logic [2:0]        MISS_LIM  = 3'(MISS_MAX);

    state_e            state_q, state_d;
    logic [2:0]        miss_q, miss_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [15:0]       dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              serr_q, serr_d;
    logic              perr_q, perr_d;
    logic              cnt_inc, cnt_load1, cnt_clr;
    logic [SLOT_W-1:0] slot_cnt;
    logic [2:0]        miss_next;

    assign miss_next = miss_q + 3'd1;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .load1 (cnt_load1),
        .clr   (cnt_clr),
        .cnt   (slot_cnt)
    );

    // Per-strobe frame tracking: capture bits, detect sync faults, publish completed frames
    always_comb begin
        state_d   = state_q;
        miss_d    = miss_q;
        shadow_d  = shadow_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        serr_d    = 1'b0;
        perr_d    = 1'b0;
        cnt_inc   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_clr   = 1'b0;
        if (din_en) begin
            case (state_q)
                HUNT: begin
                    if (fsync) begin
                        shadow_d[0] = din;
                        cnt_load1   = 1'b1;
                        miss_d      = 3'd0;
                        state_d     = RECV;
                    end
                end
                RECV: begin
                    if (slot_cnt == '0) begin
                        if (fsync) begin
                            miss_d      = 3'd0;
                            shadow_d[0] = din;
                            cnt_load1   = 1'b1;
                        end else begin
                            serr_d = 1'b1;
                            if (miss_next == MISS_LIM) begin
                                // Too many missing syncs: drop lock and discard this bit
                                state_d = HUNT;
                                miss_d  = 3'd0;
                                cnt_clr = 1'b1;
                            end else begin
                                miss_d      = miss_next;
                                shadow_d[0] = din;
                                cnt_load1   = 1'b1;
                            end
                        end
                    end else if (fsync) begin
                        // Early sync: abandon the partial frame and restart at slot 0
                        serr_d      = 1'b1;
                        shadow_d[0] = din;
                        cnt_load1   = 1'b1;
                    end else if (slot_cnt == LAST_SLOT) begin
`ifdef TDM_DEMUX_PARITY_EN
                        dout_d = shadow_q;
                        perr_d = din ^ (^shadow_q);
`else
                        dout_d = {din, shadow_q[14:0]};
`endif
                        valid_d = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        shadow_d[slot_cnt[3:0]] = din;
                        cnt_inc                 = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // State, frame and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            miss_q   <= 3'd0;
            shadow_q <= 16'h0000;
            dout_q   <= 16'h0000;
            valid_q  <= 1'b0;
            serr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            miss_q   <= miss_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            serr_q   <= serr_d;
            perr_q   <= perr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign slot       = slot_cnt[3:0];
    assign locked     = (state_q == RECV);
    assign sync_err   = serr_q;
    assign parity_err = perr_q;

endmodule

// File: doc/tdm_demux16.md
TDM_DEMUX16 -- requirements
Module: tdm_demux16

Interface
REQ-001 SHALL have parameter MISS_MAX, default 2, meaning the number of consecutive missing frame syncs tolerated before lock is dropped (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port din, input, 1, serial TDM data bit.
REQ-005 SHALL have port din_en, input, 1, bit strobe; din and fsync are sampled only when din_en=1.
REQ-006 SHALL have port fsync, input, 1, frame-sync marker qualifying the sampled bit as slot 0.
REQ-007 SHALL have port dout, output, 16, last completed frame; bit n is slot n, the inverse of 16:1 mux select n.
REQ-008 SHALL have port dout_valid, output, 1, one-cycle pulse when dout updates.
REQ-009 SHALL have port slot, output, 4, index of the next slot expected.
REQ-010 SHALL have port locked, output, 1, high while the state is RECV.
REQ-011 SHALL have port sync_err, output, 1, one-cycle pulse on an early or missing fsync.
REQ-012 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch (see Configuration).

Function
REQ-013 SHALL implement the states HUNT and RECV.
REQ-014 In HUNT, the block SHALL ignore samples with fsync=0; on din_en=1 with fsync=1, it SHALL write din to shadow[0], set slot=1 and enter RECV.
REQ-015 In RECV, each din_en=1 sample SHALL write din to shadow[slot] and increment slot.
REQ-016 On the sample completing the frame (slot 15, or slot 16 when parity is enabled), dout<=shadow with that bit merged, dout_valid=1 for one cycle, and slot wraps to 0.
REQ-017 Latency SHALL be exactly one clock: dout and dout_valid are visible the cycle after the last bit is sampled.
REQ-018 In RECV, fsync=1 at slot!=0 SHALL pulse sync_err, discard the partial frame without asserting dout_valid, and treat the bit as slot 0 (slot=1).
REQ-019 In RECV, fsync=0 at slot 0 SHALL pulse sync_err, increment the miss counter and still accept the bit as slot 0.
REQ-020 A sample with fsync=1 at slot 0 SHALL clear the miss counter.
REQ-021 When the miss counter reaches MISS_MAX, the block SHALL go to HUNT, drop locked, clear the counter and discard that bit.
REQ-022 When din_en=0, all state SHALL be held and the pulses SHALL be low.
REQ-023 dout SHALL hold its value between frames and SHALL never change without dout_valid.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=HUNT, slot=0, shadow=0, dout=16'h0000, miss counter=0, and dout_valid, locked, sync_err and parity_err all 0.
REQ-025 rst SHALL take priority over din_en and fsync.
REQ-026 A frame interrupted by rst SHALL never produce dout_valid.

Configuration
REQ-027 Macro TDM_DEMUX_PARITY_EN defined: the frame SHALL be 17 slots, with slot 16 carrying even parity over slots 0..15.
REQ-028 With TDM_DEMUX_PARITY_EN, a mismatch SHALL pulse parity_err together with dout_valid, and dout SHALL still update.
REQ-029 Macro TDM_DEMUX_PARITY_EN undefined: the frame SHALL be 16 slots and parity_err SHALL be tied to 0.

Structure
REQ-030 Package tdm_pkg SHALL hold the SLOTS=16 constant, the frame-length constant and the state enum {HUNT, RECV}.
REQ-031 Sub-module tdm_slot_counter SHALL hold the wrapping slot counter with load-to-1 and clear inputs; all other logic stays in tdm_demux16.

Verification
REQ-032 Reset, then frame 16'haf82 with fsync on slot 0 and continuous din_en: one cycle after the last bit, dout=16'haf82, dout_valid pulses once and locked=1.
REQ-033 Same frame with din_en low on every other cycle: same dout=16'haf82, with dout_valid only after the 16th strobed bit.
REQ-034 fsync asserted at slot 9 mid-frame: sync_err pulses, no dout_valid for the partial frame, and the next full frame 16'h1234 appears correctly.
REQ-035 MISS_MAX=2 and two consecutive frames without fsync: sync_err pulses twice, locked falls to 0, and bits with fsync=0 are ignored until the next fsync.
REQ-036 rst asserted at slot 7: all outputs return to reset values next cycle and no dout_valid follows.
REQ-037 With TDM_DEMUX_PARITY_EN, frame 16'haf82 with parity bit 1 (wrong): dout=16'haf82, and dout_valid and parity_err pulse together.
